// File: rtl/oc8051_stack_ctrl.sv
// oc8051_stack_ctrl: stack-pointer controller for the oc8051 core.
// Holds SP, generates the internal-RAM write address for pushes (pre-increment)
// and the read address for pops (post-decrement). SP is writable from the SFR
// bus. Defining OC8051_SP_GUARD_EN adds a programmable stack limit with sticky
// overflow/underflow flags; the default build has neither.
module oc8051_stack_ctrl #(
  parameter int            AW       = 8,
  parameter logic [AW-1:0] RST_SP   = 'h07,
  parameter logic [7:0]    SP_ADDR  = 8'h81,
  parameter logic [7:0]    LIM_ADDR = 8'h8F,
  parameter logic [AW-1:0] LIM_RST  = '1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          wr,
  input  logic          wr_bit,
  input  logic [7:0]    wr_addr,
  input  logic [AW-1:0] data_in,
  input  logic          clr_flags,
  output logic [AW-1:0] sp_out,
  output logic [AW-1:0] lim_out,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [AW-1:0] mem_raddr,
  output logic [AW-1:0] depth,
  output logic          ovf,
  output logic          unf
);

  localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [AW-1:0] sp_q;
  logic [AW-1:0] sp_d;
  logic          sp_wr;
  logic          push_req;
  logic          pop_req;
  logic          stack_full;
  logic          stack_empty;
  logic          push_eff;
  logic          pop_eff;

  // Requests seen while reset is held must not reach the RAM strobes.
  assign push_req = push & ~rst;
  assign pop_req  = pop  & ~rst;

  // A byte write to SP wins over any stack operation in the same cycle.
  assign sp_wr = wr & ~wr_bit & (wr_addr == SP_ADDR);

  assign push_eff = push_req & ~stack_full  & ~sp_wr;
  assign pop_eff  = pop_req  & ~stack_empty & ~sp_wr;

`ifdef OC8051_SP_GUARD_EN
  logic [AW-1:0] lim_q;
  logic          lim_wr;
  logic          ovf_q;
  logic          unf_q;
  logic          ovf_set;
  logic          unf_set;

  assign lim_wr      = wr & ~wr_bit & (wr_addr == LIM_ADDR);
  assign stack_full  = (sp_q == lim_q);
  assign stack_empty = (sp_q == RST_SP);

  // A blocked request raises its flag, except when an SP write drops it anyway.
  assign ovf_set = push_req & stack_full  & ~sp_wr;
  assign unf_set = pop_req  & stack_empty & ~sp_wr;

  // Limit register: loads independently of any SP write in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lim_q <= LIM_RST;
    end else if (lim_wr) begin
      lim_q <= data_in;
    end
  end

  // Sticky flags: a same-cycle set beats clr_flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_set | (ovf_q & ~clr_flags);
      unf_q <= unf_set | (unf_q & ~clr_flags);
    end
  end

  assign lim_out = lim_q;
  assign ovf     = ovf_q;
  assign unf     = unf_q;
`else
  logic guard_unused;

  assign stack_full   = 1'b0;
  assign stack_empty  = 1'b0;
  assign lim_out      = '0;
  assign ovf          = 1'b0;
  assign unf          = 1'b0;
  assign guard_unused = &{1'b0, clr_flags, (wr_addr == LIM_ADDR)};
`endif

  // Next-SP selection in priority order: SFR write, replace-top, push, pop, hold.
  always_comb begin
    // NOTE: default first so every path assigns sp_d and no latch is inferred.
    sp_d = sp_q;
    if (sp_wr) begin
      sp_d = data_in;
    end else if (push_eff && pop_eff) begin
      sp_d = sp_q;
    end else if (push_eff) begin
      sp_d = sp_q + ONE;
    end else if (pop_eff) begin
      sp_d = sp_q - ONE;
    end
  end

  // SP register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments for state so all flops update together.
    if (rst) begin
      sp_q <= RST_SP;
    end else begin
      sp_q <= sp_d;
    end
  end

  // Replace-top overwrites the current top; a plain push writes one slot above.
  assign mem_we    = push_eff;
  assign mem_waddr = (push_eff & pop_eff) ? sp_q : (sp_q + ONE);
  assign mem_raddr = sp_q;
  assign depth     = sp_q - RST_SP;
  assign sp_out    = sp_q;

endmodule
